// File: rtl/alu_iterative_pkg.sv
// Shared definitions for the EX-stage ALU: operation codes, multiplier FSM states
// and default widths.
package alu_iterative_pkg;

  localparam int CRTL_LEN     = 3;
  localparam int DATA_W_DEF   = 32;
  localparam int MUL_STEP_DEF = 4;

  typedef enum logic [CRTL_LEN-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_XOR  = 3'd3,
    OP_SLL  = 3'd4,
    OP_SRAI = 3'd5,
    OP_MUL  = 3'd6
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  function automatic logic is_mul(input logic [CRTL_LEN-1:0] op);
    return (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_iterative_if.sv
// ID/EX -> ALU -> EX/MEM signal bundle; master drives the operation, slave is the ALU.
interface alu_iterative_if
  import alu_iterative_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic                valid_i;
  logic [CRTL_LEN-1:0] ALUCtrl_i;
  logic [DATA_W-1:0]   data1_i;
  logic [DATA_W-1:0]   data2_i;
  logic [DATA_W-1:0]   data_o;
  logic                zero_o;
  logic                stall_o;

  modport master (
    output valid_i, ALUCtrl_i, data1_i, data2_i,
    input  data_o, zero_o, stall_o
  );

  modport slave (
    input  valid_i, ALUCtrl_i, data1_i, data2_i,
    output data_o, zero_o, stall_o
  );
endinterface

// File: rtl/alu_iterative_mul_iter.sv
// Iterative shift-add multiplier: consumes MUL_STEP multiplier bits per cycle and
// keeps the IDLE/BUSY/DONE sequencing; only the low DATA_W product bits are kept.
module alu_iterative_mul_iter
  import alu_iterative_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MUL_STEP = MUL_STEP_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] mcand_i,
  input  logic [DATA_W-1:0] mplier_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);
  localparam int STEPS = DATA_W / MUL_STEP;
  localparam int CNT_W = $clog2(STEPS) + 1;

  mul_state_e        state_q, state_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] product_q, product_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] partial_s;

  // Next-state and datapath update for one multiplier step.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    count_d   = count_q;
    partial_s = (mcand_q * DATA_W'(mplier_q[MUL_STEP-1:0])) << (32'(count_q) * MUL_STEP);
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mcand_d   = mcand_i;
          mplier_d  = mplier_i;
          product_d = '0;
          count_d   = '0;
          state_d   = ST_BUSY;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_BUSY: begin
        product_d = product_q + partial_s;
        mplier_d  = mplier_q >> MUL_STEP;
        count_d   = count_q + CNT_W'(1);
        if (count_q == CNT_W'(STEPS - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      // The finished MUL is still in ID/EX here, so never restart from DONE.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial product.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      count_q   <= count_d;
    end
  end

  assign busy_o    = (state_q == ST_BUSY);
  assign done_o    = (state_q == ST_DONE);
  assign product_o = product_q;

endmodule

// File: rtl/alu_iterative.sv
// EX-stage ALU: single-cycle ops combinationally, MUL via the iterative multiplier
// with stall_o freezing the front of the pipeline until the product is ready.
module alu_iterative
  import alu_iterative_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MUL_STEP = MUL_STEP_DEF
) (
  input logic              clk_i,
  input logic              rst_i,
  alu_iterative_if.slave   bus
);
  logic              start_s;
  logic              busy_s;
  logic              done_s;
  logic [DATA_W-1:0] product_s;
  logic [DATA_W-1:0] alu_s;
  logic [DATA_W-1:0] result_s;

  assign start_s = bus.valid_i && is_mul(bus.ALUCtrl_i);

  alu_iterative_mul_iter #(
    .DATA_W   (DATA_W),
    .MUL_STEP (MUL_STEP)
  ) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_s),
    .mcand_i   (bus.data1_i),
    .mplier_i  (bus.data2_i),
    .busy_o    (busy_s),
    .done_o    (done_s),
    .product_o (product_s)
  );

  // Single-cycle operation mux.
  always_comb begin
    alu_s = '0;
    case (bus.ALUCtrl_i)
      OP_ADD:  alu_s = bus.data1_i + bus.data2_i;
      OP_SUB:  alu_s = bus.data1_i - bus.data2_i;
      OP_AND:  alu_s = bus.data1_i & bus.data2_i;
      OP_XOR:  alu_s = bus.data1_i ^ bus.data2_i;
      OP_SLL:  alu_s = bus.data1_i << bus.data2_i[4:0];
      OP_SRAI: alu_s = $signed(bus.data1_i) >>> bus.data2_i[4:0];
      OP_MUL:  alu_s = '0;
      default: alu_s = '0;
    endcase
  end

  // The product is presented only in the DONE cycle.
  always_comb begin
    if (done_s) begin
      result_s = product_s;
    end else begin
      result_s = alu_s;
    end
  end

  assign bus.data_o  = result_s;
  assign bus.zero_o  = (result_s == '0);
  assign bus.stall_o = busy_s || (start_s && !done_s);

endmodule

// File: tb/tb_alu_iterative.sv
// Random plus directed stimulus against a plain-arithmetic reference; a negedge
// monitor retires each instruction from the expectation queue.
module tb_alu_iterative;
  import alu_iterative_pkg::*;

  localparam int DATA_W     = 32;
  localparam int MUL_STEP   = 4;
  localparam int MUL_STALLS = DATA_W / MUL_STEP + 1;

  typedef struct {
    logic [31:0] data;
    int          stalls;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   stall_cnt = 0;

  always #5 clk = ~clk;

  alu_iterative_if #(.DATA_W(DATA_W)) bus_if ();

  alu_iterative #(.DATA_W(DATA_W), .MUL_STEP(MUL_STEP)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    int          sh;
    sh = int'(b[4:0]);
    prod = {32'd0, a} * {32'd0, b};
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a ^ b;
      3'd4:    return a << sh;
      3'd5:    return $signed(a) >>> sh;
      3'd6:    return prod[31:0];
      default: return 32'd0;
    endcase
  endfunction

  // Issue one instruction and hold it in ID/EX until stall_o releases it.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    int k;
    exp_t e;
    k = 0;
    e.data   = model(op, a, b);
    e.stalls = (op == 3'd6) ? MUL_STALLS : 0;
    e.name   = name;
    sb.push_back(e);
    bus_if.valid_i   = 1'b1;
    bus_if.ALUCtrl_i = op;
    bus_if.data1_i   = a;
    bus_if.data2_i   = b;
    forever begin
      @(negedge clk);
      if (!bus_if.stall_o) break;
      k++;
      if (k > 40) begin
        check({name, "_stall_bound"}, 32'(k), 32'(MUL_STALLS));
        break;
      end
      @(posedge clk);
      #1;
      if (k <= 5) begin
        bus_if.valid_i   = 1'($urandom_range(0, 1));
        bus_if.ALUCtrl_i = 3'($urandom_range(0, 7));
        bus_if.data1_i   = $urandom;
        bus_if.data2_i   = $urandom;
      end else begin
        bus_if.valid_i   = 1'b1;
        bus_if.ALUCtrl_i = op;
        bus_if.data1_i   = a;
        bus_if.data2_i   = b;
      end
    end
    @(posedge clk);
    #1;
    bus_if.valid_i = 1'b0;
  endtask

  task automatic bubble(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus_if.valid_i   = 1'b0;
    bus_if.ALUCtrl_i = op;
    bus_if.data1_i   = a;
    bus_if.data2_i   = b;
    @(negedge clk);
    check("bubble_stall", 32'(bus_if.stall_o), 32'd0);
    if (op != 3'd6) check("bubble_data", bus_if.data_o, model(op, a, b));
    @(posedge clk);
    #1;
  endtask

  // Monitor: retire an instruction whenever a valid op is presented unstalled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt = 0;
      end else if (bus_if.stall_o) begin
        stall_cnt++;
      end else if (bus_if.valid_i) begin
        if (sb.size() == 0) begin
          check("unexpected_result", bus_if.data_o, 32'd0);
        end else begin
          e = sb.pop_front();
          check({e.name, "_data"}, bus_if.data_o, e.data);
          check({e.name, "_zero"}, 32'(bus_if.zero_o), 32'(e.data == 32'd0));
          check({e.name, "_stalls"}, 32'(stall_cnt), 32'(e.stalls));
        end
        stall_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int k;
    logic [2:0] op;
    bus_if.valid_i   = 1'b0;
    bus_if.ALUCtrl_i = 3'd0;
    bus_if.data1_i   = 32'd0;
    bus_if.data2_i   = 32'd0;
    #12;
    check("reset_data", bus_if.data_o, 32'd0);
    check("reset_zero", 32'(bus_if.zero_o), 32'd1);
    check("reset_stall", 32'(bus_if.stall_o), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(3'd0, 32'd5, 32'd7, "add");
    run_op(3'd1, 32'd3, 32'd5, "sub");
    run_op(3'd5, 32'h8000_0000, 32'd4, "srai");
    run_op(3'd4, 32'd1, 32'd31, "sll");
    run_op(3'd3, 32'hA5A5_1234, 32'hA5A5_1234, "xor_eq");
    run_op(3'd7, 32'h1234_5678, 32'h1, "unknown");
    run_op(3'd6, 32'h0001_0003, 32'h0000_0007, "mul_small");
    run_op(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_ones");
    run_op(3'd6, 32'h1234_5678, 32'h9ABC_DEF0, "mul_b2b_a");
    run_op(3'd6, 32'hDEAD_BEEF, 32'h0000_0100, "mul_b2b_b");
    bubble(3'd6, 32'h0000_0003, 32'h0000_0005);

    // Reset in BUSY cycle 4 (fifth stall cycle).
    bus_if.valid_i   = 1'b1;
    bus_if.ALUCtrl_i = 3'd6;
    bus_if.data1_i   = 32'h0BAD_F00D;
    bus_if.data2_i   = 32'h0000_1234;
    k = 0;
    for (int i = 0; i < 20 && k < 5; i++) begin
      @(negedge clk);
      if (bus_if.stall_o) k++;
    end
    check("rst_reach_busy4", 32'(k), 32'd5);
    #1;
    bus_if.valid_i = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_stall_drop", 32'(bus_if.stall_o), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    run_op(3'd6, 32'h0000_0123, 32'h0000_0456, "mul_after_rst");

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) begin
        bubble(op, $urandom, $urandom);
      end else begin
        run_op(op, $urandom, $urandom, "rand");
      end
    end

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
